// File: rtl/tm1638_pkg.sv
// Shared definitions for the TM1638 key reader and display writer.
// Holds the command byte, FSM encoding, default timing and the key-map helper.
package tm1638_pkg;

    localparam logic [7:0] CMD_READ_KEYS = 8'h42;
    localparam int         CLK_DIV_DEF   = 25;
    localparam int         TWAIT_DEF     = 100;

    // Each scanned byte carries two keys, at these bit positions.
    localparam int         KEY_BIT_LO    = 0;
    localparam int         KEY_BIT_HI    = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_STB_SETUP,
        ST_CMD,
        ST_WAIT,
        ST_READ,
        ST_STB_HOLD,
        ST_DONE
    } state_t;

    function automatic logic [7:0] key_map(input logic [31:0] w_bytes);
        logic [7:0] k;
        k = '0;
        for (int i = 0; i < 4; i++) begin
            k[i]     = w_bytes[8*i + KEY_BIT_LO];
            k[i + 4] = w_bytes[8*i + KEY_BIT_HI];
        end
        return k;
    endfunction

endpackage

// File: rtl/tm1638_bit_timer.sv
// sclk phase and bit counter: each bit is CLK_DIV cycles low then CLK_DIV high.
// Counters clear whenever the timer is disabled, so every enable starts at bit 0.
module tm1638_bit_timer
    import tm1638_pkg::*;
#(
    parameter int CLK_DIV = CLK_DIV_DEF
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_en,
    input  logic [5:0] i_nbits,
    output logic       o_sclk,
    output logic       o_sclk_fall,
    output logic       o_sclk_rise,
    output logic       o_bit_done,
    output logic       o_last,
    output logic [4:0] o_bit_idx
);

    localparam int PH_W = $clog2(2 * CLK_DIV);

    logic [PH_W-1:0] r_phase;
    logic [4:0]      r_bit;
    logic            w_wrap;

    assign w_wrap      = i_en && (r_phase == PH_W'(2 * CLK_DIV - 1));
    assign o_sclk      = !i_en || (r_phase >= PH_W'(CLK_DIV));
    assign o_sclk_fall = i_en && (r_phase == '0);
    assign o_sclk_rise = i_en && (r_phase == PH_W'(CLK_DIV));
    assign o_bit_done  = w_wrap;
    assign o_last      = ({1'b0, r_bit} == (i_nbits - 6'd1));
    assign o_bit_idx   = r_bit;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_phase <= '0;
            r_bit   <= '0;
        end else if (!i_en) begin
            r_phase <= '0;
            r_bit   <= '0;
        end else if (w_wrap) begin
            r_phase <= '0;
            r_bit   <= o_last ? 5'd0 : r_bit + 5'd1;
        end else begin
            r_phase <= r_phase + PH_W'(1);
        end
    end

endmodule

// File: rtl/tm1638_key_reader.sv
// One-shot TM1638 key scan: send the read command, wait, clock in 4 bytes
// and publish the 8 key states with a rising-edge mask on the done cycle.
module tm1638_key_reader
    import tm1638_pkg::*;
#(
    parameter int CLK_DIV = CLK_DIV_DEF,
    parameter int TWAIT   = TWAIT_DEF
) (
    input  logic       clk_50M,
    input  logic       reset_n,
    input  logic       start,
    output logic       busy,
    output logic       done,
    output logic [7:0] keys,
    output logic [7:0] key_rise,
    output logic       key_valid,
    output logic       stb,
    output logic       sclk,
    output logic       dio_out,
    output logic       dio_oe,
    input  logic       dio_in
);

    localparam int DLY_W = 16;

    state_t          r_state, w_next;
    logic [DLY_W-1:0] r_dly;
    logic            w_en, w_sclk, w_fall, w_rise, w_bit_done, w_last;
    logic [4:0]      w_bit_idx;
    logic [5:0]      w_nbits;
    logic [31:0]     w_cmd_word;
    logic [1:0]      r_sync;
    logic            r_rise_d;
    logic [31:0]     r_shift;
    logic            r_dio, w_dio;
    logic [7:0]      r_keys, r_key_rise, w_new_keys;
    logic            r_key_valid;

    assign w_en       = (r_state == ST_CMD) || (r_state == ST_READ);
    assign w_nbits    = (r_state == ST_READ) ? 6'd32 : 6'd8;
    assign w_cmd_word = {24'h0, CMD_READ_KEYS};
    assign w_new_keys = key_map(r_shift);

    tm1638_bit_timer #(.CLK_DIV(CLK_DIV)) u_timer (
        .i_clk       (clk_50M),
        .i_rst_n     (reset_n),
        .i_en        (w_en),
        .i_nbits     (w_nbits),
        .o_sclk      (w_sclk),
        .o_sclk_fall (w_fall),
        .o_sclk_rise (w_rise),
        .o_bit_done  (w_bit_done),
        .o_last      (w_last),
        .o_bit_idx   (w_bit_idx)
    );

    always_ff @(posedge clk_50M or negedge reset_n) begin
        if (!reset_n) r_state <= ST_IDLE;
        else          r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:      if (start) w_next = ST_STB_SETUP;
            ST_STB_SETUP: if (r_dly == DLY_W'(CLK_DIV - 1)) w_next = ST_CMD;
            ST_CMD:       if (w_bit_done && w_last) w_next = ST_WAIT;
            ST_WAIT:      if (r_dly == DLY_W'(TWAIT - 1)) w_next = ST_READ;
            ST_READ:      if (w_bit_done && w_last) w_next = ST_STB_HOLD;
            ST_STB_HOLD:  if (r_dly == DLY_W'(CLK_DIV - 1)) w_next = ST_DONE;
            ST_DONE:      w_next = ST_IDLE;
            default:      w_next = ST_IDLE;
        endcase
    end

    // dio_out is loaded only on the sclk-fall cycle and held for the rest of the bit.
    always_comb begin
        busy    = (r_state != ST_IDLE);
        done    = (r_state == ST_DONE);
        stb     = (r_state == ST_IDLE) || (r_state == ST_DONE);
        sclk    = w_sclk;
        dio_oe  = (r_state == ST_CMD);
        w_dio   = 1'b0;
        if (r_state == ST_CMD)
            w_dio = w_fall ? w_cmd_word[w_bit_idx] : r_dio;
        dio_out = w_dio;
    end

    assign keys      = r_keys;
    assign key_rise  = r_key_rise;
    assign key_valid = r_key_valid;

    // r_rise_d plus the 2-flop synchronizer land the sample on dio_in as seen at the sclk rise.
    always_ff @(posedge clk_50M or negedge reset_n) begin
        if (!reset_n) begin
            r_dly       <= '0;
            r_sync      <= '0;
            r_rise_d    <= 1'b0;
            r_shift     <= '0;
            r_dio       <= 1'b0;
            r_keys      <= '0;
            r_key_rise  <= '0;
            r_key_valid <= 1'b0;
        end else begin
            r_dly      <= (w_next != r_state || r_state == ST_IDLE) ? '0 : r_dly + DLY_W'(1);
            r_sync     <= {r_sync[0], dio_in};
            r_rise_d   <= w_rise && (r_state == ST_READ);
            r_dio      <= w_dio;
            r_key_rise <= '0;
            if (r_rise_d)
                r_shift <= {r_sync[1], r_shift[31:1]};
            if (r_state == ST_STB_HOLD && w_next == ST_DONE) begin
                r_keys      <= w_new_keys;
                r_key_rise  <= w_new_keys & ~r_keys;
                r_key_valid <= 1'b1;
            end
        end
    end

endmodule
